// File: rtl/gpr_pkg.sv
// gpr_pkg: shared GPR-file constants and the operand bundle handed to execute.
package gpr_pkg;
   localparam int NREG = 8;
   localparam int AW = $clog2(NREG);
   localparam int DW = 16;
   localparam int TAGW = 8;
   localparam logic [AW-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [DW-1:0]   op1;
      logic [DW-1:0]   op2;
      logic [AW-1:0]   rd;
      logic            rd_we;
      logic [TAGW-1:0] tag;
   } operand_bundle_t;
endpackage

// File: rtl/gpr_operand_fetch_if.sv
// gpr_operand_fetch_if: decode/execute handshakes, GPR read ports and writeback mirror.
interface gpr_operand_fetch_if;
   import gpr_pkg::*;
   logic            in_valid, in_ready, in_rd_we;
   logic [AW-1:0]   in_rs1, in_rs2, in_rd;
   logic [TAGW-1:0] in_tag;
   logic [AW-1:0]   rf_raddr1, rf_raddr2;
   logic [DW-1:0]   rf_rdata1, rf_rdata2;
   logic            wb_valid, flush;
   logic [AW-1:0]   wb_rd;
   logic [DW-1:0]   wb_data;
   logic            out_valid, out_ready, out_rd_we;
   logic [DW-1:0]   out_op1, out_op2;
   logic [AW-1:0]   out_rd;
   logic [TAGW-1:0] out_tag;
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_tag, rf_rdata1, rf_rdata2,
             wb_valid, wb_rd, wb_data, flush, out_ready,
      input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_op1, out_op2, out_rd, out_rd_we, out_tag
   );
   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_tag, rf_rdata1, rf_rdata2,
             wb_valid, wb_rd, wb_data, flush, out_ready,
      output in_ready, rf_raddr1, rf_raddr2, out_valid, out_op1, out_op2, out_rd, out_rd_we, out_tag
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: one pending-write bit per GPR; a set beats a clear on the same index.
module gpr_scoreboard
   import gpr_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_idx,
   input  logic          fl_en,
   input  logic [AW-1:0] fl_idx,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic [AW-1:0] rd,
   output logic          p1,
   output logic          p2,
   output logic          pd
);
   logic [NREG-1:0] pend, pend_n;
   always_comb begin
      pend_n = pend;
      if (clr_en) pend_n[clr_idx] = 1'b0;
      if (fl_en) pend_n[fl_idx] = 1'b0;
      if (set_en) pend_n[set_idx] = 1'b1;
      pend_n[REG_ZERO] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) pend <= '0;
      else pend <= pend_n;
   assign p1 = pend[rs1];
   assign p2 = pend[rs2];
   assign pd = pend[rd];
endmodule

// File: rtl/gpr_operand_fetch.sv
// gpr_operand_fetch: issues decoded instructions with GPR operands, stalling on RAW/WAW.
// GPR_OF_BYPASS_EN: forward same-cycle writeback data instead of waiting a cycle.
module gpr_operand_fetch
   import gpr_pkg::*;
(
   input logic          clk,
   input logic          rst,
   gpr_operand_fetch_if.slave bus
);
   logic p1, p2, pd, clr1, clr2, clrd, haz, acc, vld;
   logic [DW-1:0] op1, op2;
   operand_bundle_t q;
`ifdef GPR_OF_BYPASS_EN
   assign clr1 = bus.wb_valid && bus.wb_rd == bus.in_rs1 && bus.in_rs1 != REG_ZERO;
   assign clr2 = bus.wb_valid && bus.wb_rd == bus.in_rs2 && bus.in_rs2 != REG_ZERO;
   assign clrd = bus.wb_valid && bus.wb_rd == bus.in_rd;
`else
   assign clr1 = 1'b0;
   assign clr2 = 1'b0;
   assign clrd = 1'b0;
`endif
   assign haz = (p1 & ~clr1) | (p2 & ~clr2) | (bus.in_rd_we & pd & ~clrd);
   assign bus.in_ready = ~haz & (~vld | bus.out_ready) & ~bus.flush;
   assign acc = bus.in_valid & bus.in_ready;
   assign bus.rf_raddr1 = bus.in_rs1;
   assign bus.rf_raddr2 = bus.in_rs2;
   // r0 is forced to zero here rather than trusting the register file
   assign op1 = bus.in_rs1 == REG_ZERO ? '0 : clr1 ? bus.wb_data : bus.rf_rdata1;
   assign op2 = bus.in_rs2 == REG_ZERO ? '0 : clr2 ? bus.wb_data : bus.rf_rdata2;
   gpr_scoreboard u_sb (
      .clk(clk), .rst(rst),
      .set_en(acc & bus.in_rd_we & (bus.in_rd != REG_ZERO)), .set_idx(bus.in_rd),
      .clr_en(bus.wb_valid), .clr_idx(bus.wb_rd),
      .fl_en(bus.flush & vld & q.rd_we), .fl_idx(q.rd),
      .rs1(bus.in_rs1), .rs2(bus.in_rs2), .rd(bus.in_rd),
      .p1(p1), .p2(p2), .pd(pd)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld <= 1'b0;
         q <= '0;
      end else if (acc) begin
         vld <= 1'b1;
         q <= '{op1: op1, op2: op2, rd: bus.in_rd, rd_we: bus.in_rd_we, tag: bus.in_tag};
      end else if (bus.flush || bus.out_ready) vld <= 1'b0;
   assign bus.out_valid = vld;
   assign bus.out_op1 = q.op1;
   assign bus.out_op2 = q.op2;
   assign bus.out_rd = q.rd;
   assign bus.out_rd_we = q.rd_we;
   assign bus.out_tag = q.tag;
endmodule

// File: tb/tb_gpr_operand_fetch.sv
// tb_gpr_operand_fetch: vector table, hazard/flush/reset sequences and random traffic vs a reference model.
module tb_gpr_operand_fetch;
   import gpr_pkg::*;
`ifdef GPR_OF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   gpr_operand_fetch_if bus();
   gpr_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));
   logic [DW-1:0] rf [NREG];
   assign bus.rf_rdata1 = rf[bus.rf_raddr1];
   assign bus.rf_rdata2 = rf[bus.rf_raddr2];
   int nerr = 0, nchk = 0;
   logic [NREG-1:0] m_pend;
   logic m_ov, m_we, last_rdy;
   logic [DW-1:0] m_op1, m_op2;
   logic [AW-1:0] m_rd;
   logic [TAGW-1:0] m_tag;
   typedef struct {
      logic v; logic [2:0] rs1, rs2, rd; logic we; logic [7:0] tag; logic ordy;
      logic wbv; logic [2:0] wbrd; logic [15:0] wbd; logic fl;
      logic e_rdy, e_ov; logic [15:0] e_op1, e_op2;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic v, input logic [2:0] rs1, rs2, rd, input logic we,
                         input logic [7:0] tag, input logic ordy);
      bus.in_valid = v; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
      bus.in_rd_we = we; bus.in_tag = tag; bus.out_ready = ordy;
   endtask

   task automatic set_side(input logic wbv, input logic [2:0] wbrd, input logic [15:0] wbd, input logic fl);
      bus.wb_valid = wbv; bus.wb_rd = wbrd; bus.wb_data = wbd; bus.flush = fl;
   endtask

   function automatic logic credit(input logic [2:0] n);
      return BYP && bus.wb_valid && bus.wb_rd == n && n != 3'd0;
   endfunction

   function automatic logic [15:0] value(input logic [2:0] n);
      if (n == 3'd0) return 16'h0;
      return credit(n) ? bus.wb_data : rf[n];
   endfunction

   // one clock: check in_ready before the edge, advance the model, check outputs after
   task automatic tick();
      logic rdy, acc, drop;
      logic [NREG-1:0] np;
      logic [15:0] v1, v2;
      logic wbv;
      logic [2:0] wbrd;
      logic [15:0] wbd;
      #2;
      rdy = !((m_pend[bus.in_rs1] && !credit(bus.in_rs1)) || (m_pend[bus.in_rs2] && !credit(bus.in_rs2))
              || (bus.in_rd_we && m_pend[bus.in_rd] && !credit(bus.in_rd)))
            && (!m_ov || bus.out_ready) && !bus.flush;
      acc = bus.in_valid && rdy;
      drop = bus.flush || bus.out_ready;
      v1 = value(bus.in_rs1);
      v2 = value(bus.in_rs2);
      last_rdy = bus.in_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      chk("raddr", 32'({bus.rf_raddr1, bus.rf_raddr2}), 32'({bus.in_rs1, bus.in_rs2}));
      np = m_pend;
      if (bus.wb_valid) np[bus.wb_rd] = 1'b0;
      if (bus.flush && m_ov && m_we) np[m_rd] = 1'b0;
      if (acc && bus.in_rd_we && bus.in_rd != 3'd0) np[bus.in_rd] = 1'b1;
      wbv = bus.wb_valid; wbrd = bus.wb_rd; wbd = bus.wb_data;
      if (acc) begin
         m_op1 = v1; m_op2 = v2; m_rd = bus.in_rd; m_we = bus.in_rd_we; m_tag = bus.in_tag;
      end
      @(posedge clk);
      #1;
      m_pend = np;
      m_ov = acc ? 1'b1 : drop ? 1'b0 : m_ov;
      if (wbv && wbrd != 3'd0) rf[wbrd] = wbd;
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("pend", 32'(dut.u_sb.pend), 32'(m_pend));
      if (m_ov) begin
         chk("out_ops", {bus.out_op1, bus.out_op2}, {m_op1, m_op2});
         chk("out_ctl", 32'({bus.out_rd, bus.out_rd_we, bus.out_tag}), 32'({m_rd, m_we, m_tag}));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_pend = '0; m_ov = 1'b0;
      set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h0, 1'b0);
      set_side(1'b0, 3'd0, 16'h0, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ops", {bus.out_op1, bus.out_op2}, 32'd0);
      chk("rst_ctl", 32'({bus.out_rd, bus.out_rd_we, bus.out_tag}), 32'd0);
      chk("rst_pend", 32'(dut.u_sb.pend), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) rf[i] = 16'h1000 + 16'(i);
      rf[0] = 16'hFFFF;
      tbl[0] = '{1'b1,3'd0,3'd0,3'd0,1'b1,8'h11,1'b1,1'b0,3'd0,16'h0,1'b0,1'b1,1'b1,16'h0,16'h0};
      tbl[1] = '{1'b1,3'd1,3'd2,3'd3,1'b1,8'h22,1'b1,1'b0,3'd0,16'h0,1'b0,1'b1,1'b1,16'h1001,16'h1002};
      tbl[2] = '{1'b1,3'd3,3'd0,3'd4,1'b0,8'h33,1'b1,1'b0,3'd0,16'h0,1'b0,1'b0,1'b0,16'h0,16'h0};
      tbl[3] = '{1'b1,3'd3,3'd0,3'd4,1'b0,8'h33,1'b1,1'b1,3'd3,16'hBEEF,1'b0,BYP,BYP,16'hBEEF,16'h0};
      tbl[4] = '{1'b1,3'd3,3'd0,3'd4,1'b0,8'h44,1'b1,1'b0,3'd0,16'h0,1'b0,1'b1,1'b1,16'hBEEF,16'h0};
      tbl[5] = '{1'b1,3'd1,3'd1,3'd2,1'b1,8'h55,1'b1,1'b1,3'd2,16'h2222,1'b0,1'b1,1'b1,16'h1001,16'h1001};
      tbl[6] = '{1'b1,3'd2,3'd0,3'd0,1'b0,8'h66,1'b1,1'b0,3'd0,16'h0,1'b0,1'b0,1'b0,16'h0,16'h0};
      do_reset();
      foreach (tbl[k]) begin
         set_in(tbl[k].v, tbl[k].rs1, tbl[k].rs2, tbl[k].rd, tbl[k].we, tbl[k].tag, tbl[k].ordy);
         set_side(tbl[k].wbv, tbl[k].wbrd, tbl[k].wbd, tbl[k].fl);
         tick();
         chk($sformatf("tbl%0d_rdy", k), 32'(last_rdy), 32'(tbl[k].e_rdy));
         chk($sformatf("tbl%0d_ov", k), 32'(bus.out_valid), 32'(tbl[k].e_ov));
         if (tbl[k].e_ov) chk($sformatf("tbl%0d_ops", k), {bus.out_op1, bus.out_op2}, {tbl[k].e_op1, tbl[k].e_op2});
      end
      // backpressure: bundle A held three cycles, then B loads
      do_reset();
      set_in(1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 8'hAA, 1'b1);
      tick();
      set_in(1'b1, 3'd3, 3'd4, 3'd0, 1'b0, 8'hBB, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_rdy", 32'(last_rdy), 32'd0);
         chk("bp_hold", 32'({bus.out_valid, bus.out_tag, bus.out_op1}), 32'({1'b1, 8'hAA, 16'h1001}));
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_rdy", 32'(last_rdy), 32'd1);
      chk("bp_load", 32'({bus.out_tag, bus.out_op1}), 32'({8'hBB, 16'hBEEF}));
      // WAW on r5, flushed before execute takes it
      do_reset();
      set_in(1'b1, 3'd1, 3'd1, 3'd5, 1'b1, 8'h55, 1'b0);
      tick();
      set_in(1'b1, 3'd1, 3'd1, 3'd5, 1'b1, 8'h56, 1'b0);
      bus.flush = 1'b1;
      tick();
      chk("fl_rdy", 32'(last_rdy), 32'd0);
      chk("fl_state", 32'({bus.out_valid, dut.u_sb.pend[5]}), 32'd0);
      bus.flush = 1'b0;
      tick();
      chk("fl_reissue", 32'({last_rdy, bus.out_valid, bus.out_tag}), 32'({2'b11, 8'h56}));
      // asynchronous reset while r5 bundle is held
      set_in(1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 8'h0, 1'b0);
      #3;
      rst = 1'b1;
      m_pend = '0; m_ov = 1'b0;
      #1;
      chk("arst_state", 32'({bus.out_valid, dut.u_sb.pend}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("arst_rdy", 32'(last_rdy), 32'd1);
      // random traffic
      do_reset();
      repeat (600) begin
         set_in(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7));
         set_side(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 9) == 0));
         tick();
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
